// File: rtl/sd_sector_pkg.sv
// Shared constants and state encodings for the SD sector packer.
package sd_sector_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int SECTOR_AW    = 9;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

  typedef enum logic [1:0] {
    W_FILL  = 2'd0,
    W_STALL = 2'd1,
    W_PAD   = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_READY = 2'd2,
    R_WAIT  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/sd_sector_bank_ram.sv
// Two 512-byte sector banks in one simple dual-port RAM, address = {bank, ptr}.
// Synchronous read with one cycle of latency; the read register holds when not enabled.
module sd_sector_bank_ram
  import sd_sector_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               we,
  input  logic [SECTOR_AW:0] waddr,
  input  logic [7:0]         wdata,
  input  logic               re,
  input  logic [SECTOR_AW:0] raddr,
  output logic [7:0]         rdata
);

  logic [7:0] mem_r [2*SECTOR_BYTES];
  logic [7:0] rdata_r;

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port output register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_r <= 8'h00;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/sd_sector_packer.sv
// Packs a UART byte stream into 512-byte sectors over two ping-pong banks for the SD writer.
// Optional idle-timeout padding of partial sectors is enabled by defining SECTOR_PAD_TIMEOUT_EN.
module sd_sector_packer
  import sd_sector_pkg::*;
#(
  parameter int CNT_W = 22
`ifdef SECTOR_PAD_TIMEOUT_EN
  ,
  parameter logic [7:0] PAD_BYTE    = 8'h00,
  parameter int         PAD_TIMEOUT = 20000
`endif
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [7:0]           in_byte,
  input  logic                 in_valid,
  output logic                 overflow,
  output logic                 sect_ready,
  output logic [7:0]           sect_byte,
  output logic [SECTOR_AW-1:0] sect_addr,
  input  logic                 rd_req,
  input  logic                 sect_done,
  output logic [CNT_W-1:0]     sect_count
);

  localparam logic [SECTOR_AW-1:0] LAST_PTR = SECTOR_AW'(SECTOR_BYTES - 1);
  localparam logic [SECTOR_AW-1:0] PTR_ONE  = SECTOR_AW'(1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

  wr_state_e            wr_state_r, wr_state_s;
  rd_state_e            rd_state_r, rd_state_s;
  bank_state_e          bank_state_r [2];
  bank_state_e          bank_state_s [2];
  logic                 wr_bank_r, wr_bank_s;
  logic                 rd_bank_r, rd_bank_s;
  logic [SECTOR_AW-1:0] wr_ptr_r, wr_ptr_s;
  logic [SECTOR_AW-1:0] sect_addr_r, sect_addr_s;
  logic [CNT_W-1:0]     sect_count_r, sect_count_s;
  logic                 overflow_r, overflow_s;
  logic                 sect_ready_r;
  logic                 ram_we_s, ram_re_s, complete_s, other_bank_s;
  logic [7:0]           ram_wdata_s;

`ifdef SECTOR_PAD_TIMEOUT_EN
  logic [31:0] idle_cnt_r;
  logic        pad_due_s;

  assign pad_due_s = (idle_cnt_r == 32'(PAD_TIMEOUT)) && (wr_ptr_r != {SECTOR_AW{1'b0}});

  // Idle cycles since the last in_valid, saturating at the timeout
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt_r <= 32'd0;
    end else if (in_valid) begin
      idle_cnt_r <= 32'd0;
    end else if (idle_cnt_r != 32'(PAD_TIMEOUT)) begin
      idle_cnt_r <= idle_cnt_r + 32'd1;
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end
`endif

  // Next-state logic for both FSMs, bank ownership and counters
  always_comb begin
    wr_state_s   = wr_state_r;
    rd_state_s   = rd_state_r;
    bank_state_s = bank_state_r;
    wr_bank_s    = wr_bank_r;
    rd_bank_s    = rd_bank_r;
    wr_ptr_s     = wr_ptr_r;
    sect_addr_s  = sect_addr_r;
    sect_count_s = sect_count_r;
    overflow_s   = overflow_r;
    ram_we_s     = 1'b0;
    ram_re_s     = 1'b0;
    complete_s   = 1'b0;
    ram_wdata_s  = in_byte;
    other_bank_s = ~wr_bank_r;

    // Read side runs first so a release in this cycle is visible to the write side
    case (rd_state_r)
      R_IDLE: begin
        if (bank_state_r[rd_bank_r] == FULL) begin
          rd_state_s = R_FETCH;
        end else begin
          rd_state_s = R_IDLE;
        end
      end
      R_FETCH: begin
        ram_re_s   = 1'b1;
        rd_state_s = R_READY;
      end
      R_READY: begin
        if (sect_done) begin
          bank_state_s[rd_bank_r] = EMPTY;
          rd_bank_s    = ~rd_bank_r;
          sect_count_s = sect_count_r + CNT_ONE;
          sect_addr_s  = {SECTOR_AW{1'b0}};
          rd_state_s   = R_IDLE;
        end else if (rd_req && (sect_addr_r != LAST_PTR)) begin
          sect_addr_s = sect_addr_r + PTR_ONE;
          rd_state_s  = R_FETCH;
        end else if (rd_req) begin
          rd_state_s = R_WAIT;
        end else begin
          rd_state_s = R_READY;
        end
      end
      R_WAIT: begin
        if (sect_done) begin
          bank_state_s[rd_bank_r] = EMPTY;
          rd_bank_s    = ~rd_bank_r;
          sect_count_s = sect_count_r + CNT_ONE;
          sect_addr_s  = {SECTOR_AW{1'b0}};
          rd_state_s   = R_IDLE;
        end else begin
          rd_state_s = R_WAIT;
        end
      end
      default: rd_state_s = R_IDLE;
    endcase

    case (wr_state_r)
      W_FILL: begin
        if (in_valid) begin
          ram_we_s = 1'b1;
          bank_state_s[wr_bank_r] = FILLING;
          wr_ptr_s   = wr_ptr_r + PTR_ONE;
          complete_s = (wr_ptr_r == LAST_PTR);
        end
`ifdef SECTOR_PAD_TIMEOUT_EN
        else if (pad_due_s) begin
          wr_state_s = W_PAD;
        end
`endif
        else begin
          wr_state_s = W_FILL;
        end
      end
      W_STALL: begin
        overflow_s = overflow_r | in_valid;
        if (bank_state_r[other_bank_s] == EMPTY) begin
          wr_bank_s = other_bank_s;
          bank_state_s[other_bank_s] = FILLING;
          wr_state_s = W_FILL;
        end else begin
          wr_state_s = W_STALL;
        end
      end
`ifdef SECTOR_PAD_TIMEOUT_EN
      W_PAD: begin
        ram_we_s    = 1'b1;
        ram_wdata_s = PAD_BYTE;
        wr_ptr_s    = wr_ptr_r + PTR_ONE;
        overflow_s  = overflow_r | in_valid;
        complete_s  = (wr_ptr_r == LAST_PTR);
      end
`endif
      default: wr_state_s = W_FILL;
    endcase

    if (complete_s) begin
      bank_state_s[wr_bank_r] = FULL;
      if (bank_state_s[other_bank_s] == EMPTY) begin
        wr_bank_s = other_bank_s;
        bank_state_s[other_bank_s] = FILLING;
        wr_state_s = W_FILL;
      end else begin
        wr_state_s = W_STALL;
      end
    end else begin
      wr_state_s = wr_state_s;
    end
  end

  // State, pointer, counter and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state_r      <= W_FILL;
      rd_state_r      <= R_IDLE;
      bank_state_r[0] <= EMPTY;
      bank_state_r[1] <= EMPTY;
      wr_bank_r       <= 1'b0;
      rd_bank_r       <= 1'b0;
      wr_ptr_r        <= {SECTOR_AW{1'b0}};
      sect_addr_r     <= {SECTOR_AW{1'b0}};
      sect_count_r    <= {CNT_W{1'b0}};
      overflow_r      <= 1'b0;
      sect_ready_r    <= 1'b0;
    end else begin
      wr_state_r   <= wr_state_s;
      rd_state_r   <= rd_state_s;
      bank_state_r <= bank_state_s;
      wr_bank_r    <= wr_bank_s;
      rd_bank_r    <= rd_bank_s;
      wr_ptr_r     <= wr_ptr_s;
      sect_addr_r  <= sect_addr_s;
      sect_count_r <= sect_count_s;
      overflow_r   <= overflow_s;
      sect_ready_r <= (rd_state_s == R_READY);
    end
  end

  sd_sector_bank_ram u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (ram_we_s),
    .waddr ({wr_bank_r, wr_ptr_r}),
    .wdata (ram_wdata_s),
    .re    (ram_re_s),
    .raddr ({rd_bank_r, sect_addr_r}),
    .rdata (sect_byte)
  );

  assign overflow   = overflow_r;
  assign sect_ready = sect_ready_r;
  assign sect_addr  = sect_addr_r;
  assign sect_count = sect_count_r;

endmodule

// File: tb/tb_sd_sector_packer.sv
// Directed bench for sd_sector_packer: table-driven sector readback plus hand-written corner sequences.
module tb_sd_sector_packer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        overflow;
  logic        sect_ready;
  logic [7:0]  sect_byte;
  logic [8:0]  sect_addr;
  logic        rd_req;
  logic        sect_done;
  logic [21:0] sect_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         steps;
    logic [8:0] addr;
    logic [7:0] data;
    logic       ready;
  } rd_vec_t;

  rd_vec_t vecs [9];

  always #5 clk = ~clk;

  sd_sector_packer #(
    .CNT_W(22)
`ifdef SECTOR_PAD_TIMEOUT_EN
    , .PAD_TIMEOUT(100)
`endif
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .overflow   (overflow),
    .sect_ready (sect_ready),
    .sect_byte  (sect_byte),
    .sect_addr  (sect_addr),
    .rd_req     (rd_req),
    .sect_done  (sect_done),
    .sect_count (sect_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    in_byte  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic write_range(input int first, input int last, input logic [7:0] xv);
    for (int i = first; i <= last; i++) write_byte(8'(i) ^ xv);
  endtask

  task automatic rd_steps(input int n);
    for (int k = 0; k < n; k++) begin
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      tick();
    end
  endtask

  task automatic done_pulse();
    sect_done = 1'b1;
    tick();
    sect_done = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    for (int k = 0; k < 50 && !sect_ready; k++) tick();
    check(name, 32'(sect_ready), 32'd1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    vecs[0] = '{0,   9'd0,   8'h00, 1'b1};
    vecs[1] = '{1,   9'd1,   8'h01, 1'b1};
    vecs[2] = '{126, 9'd127, 8'h7F, 1'b1};
    vecs[3] = '{128, 9'd255, 8'hFF, 1'b1};
    vecs[4] = '{1,   9'd256, 8'h00, 1'b1};
    vecs[5] = '{254, 9'd510, 8'hFE, 1'b1};
    vecs[6] = '{1,   9'd511, 8'hFF, 1'b1};
    vecs[7] = '{1,   9'd511, 8'hFF, 1'b0};
    vecs[8] = '{1,   9'd511, 8'hFF, 1'b0};

    rstn = 1'b0; in_byte = 8'h00; in_valid = 1'b0; rd_req = 1'b0; sect_done = 1'b0;
    do_reset();
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_ready", 32'(sect_ready), 32'd0);
    check("rst_byte", 32'(sect_byte), 32'd0);
    check("rst_addr", 32'(sect_addr), 32'd0);
    check("rst_count", 32'(sect_count), 32'd0);

    // Sector fill, latency, table-driven readback
    write_range(0, 511, 8'h00);
    check("lat_c1", 32'(sect_ready), 32'd0);
    tick();
    check("lat_c2", 32'(sect_ready), 32'd0);
    tick();
    check("lat_c3_ready", 32'(sect_ready), 32'd1);
    check("lat_c3_byte", 32'(sect_byte), 32'h00);
    for (int v = 0; v < 9; v++) begin
      rd_steps(vecs[v].steps);
      check($sformatf("vec%0d_addr", v), 32'(sect_addr), 32'(vecs[v].addr));
      check($sformatf("vec%0d_byte", v), 32'(sect_byte), 32'(vecs[v].data));
      check($sformatf("vec%0d_ready", v), 32'(sect_ready), 32'(vecs[v].ready));
    end
    done_pulse();
    check("t1_count", 32'(sect_count), 32'd1);
    check("t1_addr", 32'(sect_addr), 32'd0);
    check("t1_ready", 32'(sect_ready), 32'd0);

    // sect_done while the read side is idle is ignored
    tick(); tick(); tick();
    done_pulse();
    check("idle_done_count", 32'(sect_count), 32'd1);
    tick(); tick(); tick();
    check("idle_done_ready", 32'(sect_ready), 32'd0);

    // Both banks full, overflow, release, resume at ptr 0
    write_range(0, 511, 8'h00);
    write_range(0, 511, 8'h3C);
    check("t2_no_ovf", 32'(overflow), 32'd0);
    check("t2_ready", 32'(sect_ready), 32'd1);
    check("t2_byte", 32'(sect_byte), 32'h00);
    write_byte(8'hEE);
    check("t2_ovf", 32'(overflow), 32'd1);
    done_pulse();
    check("t2_count", 32'(sect_count), 32'd2);
    wait_ready("t2_ready_b");
    check("t2_byte_b", 32'(sect_byte), 32'h3C);
    write_range(0, 511, 8'hC3);
    check("t2_ovf_sticky", 32'(overflow), 32'd1);
    done_pulse();
    check("t2_count_c", 32'(sect_count), 32'd3);
    wait_ready("t2_ready_c");
    check("t2_byte_c0", 32'(sect_byte), 32'hC3);
    rd_steps(1);
    check("t2_byte_c1", 32'(sect_byte), 32'hC2);
    rd_steps(199);
    check("t4_addr200", 32'(sect_addr), 32'd200);
    check("t4_byte200", 32'(sect_byte), 32'h0B);

    // Reset mid-sector
    rstn = 1'b0;
    #1;
    check("t4_ready", 32'(sect_ready), 32'd0);
    check("t4_count", 32'(sect_count), 32'd0);
    check("t4_ovf", 32'(overflow), 32'd0);
    check("t4_addr", 32'(sect_addr), 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    // Release and sector completion in the same cycle
    write_range(0, 511, 8'h11);
    wait_ready("t3_ready_a");
    check("t3_addr_a", 32'(sect_addr), 32'd0);
    check("t3_byte_a", 32'(sect_byte), 32'h11);
    write_range(0, 510, 8'h77);
    in_byte = 8'h88; in_valid = 1'b1; sect_done = 1'b1;
    tick();
    in_valid = 1'b0; sect_done = 1'b0;
    check("t3_count", 32'(sect_count), 32'd1);
    check("t3_ovf", 32'(overflow), 32'd0);
    write_byte(8'h99);
    check("t3_ovf_next", 32'(overflow), 32'd0);
    wait_ready("t3_ready_b");
    check("t3_byte_b", 32'(sect_byte), 32'h77);
    write_range(1, 511, 8'h99);
    done_pulse();
    wait_ready("t3_ready_c");
    check("t3_byte_c", 32'(sect_byte), 32'h99);
    check("t3_count_c", 32'(sect_count), 32'd2);

    // Partial sector behaviour after a long idle period
    do_reset();
    write_range(0, 9, 8'hA0);
`ifdef SECTOR_PAD_TIMEOUT_EN
    begin
      int waited;
      waited = 0;
      while (!sect_ready && waited < 1000) begin
        tick();
        waited++;
      end
      check("pad_ready", 32'(sect_ready), 32'd1);
      check("pad_not_early", 32'(waited > 100), 32'd1);
    end
    check("pad_byte0", 32'(sect_byte), 32'hA0);
    rd_steps(9);
    check("pad_byte9", 32'(sect_byte), 32'hA9);
    rd_steps(1);
    check("pad_byte10", 32'(sect_byte), 32'h00);
    rd_steps(501);
    check("pad_addr511", 32'(sect_addr), 32'd511);
    check("pad_byte511", 32'(sect_byte), 32'h00);
`else
    for (int k = 0; k < 10000; k++) tick();
    check("nopad_ready", 32'(sect_ready), 32'd0);
    write_range(10, 511, 8'hA0);
    wait_ready("nopad_ready_full");
    check("nopad_byte0", 32'(sect_byte), 32'hA0);
    rd_steps(10);
    check("nopad_addr10", 32'(sect_addr), 32'd10);
    check("nopad_byte10", 32'(sect_byte), 32'hAA);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
